// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: default widths, reset/NOP encodings and
// the fetch FSM state encoding.
package pipeline_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    // imem_req is high in FETCH and DRAIN only.
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (NOP, invalid) beats load, otherwise holds.
// A bubble leaves the stored PC untouched; consumers qualify it with valid.
module if_id_reg #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic [ADDR_W-1:0]  pc_id,
    output logic [INSTR_W-1:0] instr_id,
    output logic               valid_id
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id    <= '0;
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
        end else if (bubble) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
        end else if (load) begin
            pc_id    <= load_pc;
            instr_id <= load_instr;
            valid_id <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: PC register, imem req/ack handshake, one-entry
// buffer for data that arrives during a stall, and the IF/ID register.
module if_stage_ctrl #(
    parameter int                 ADDR_W    = pipeline_pkg::ADDR_W,
    parameter int                 INSTR_W   = pipeline_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(pipeline_pkg::RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipeline_pkg::NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               flush,
    input  logic               Jump,
    input  logic               Branch,
    input  logic [ADDR_W-1:0]  JumpAddr,
    input  logic [ADDR_W-1:0]  BranchAddr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [ADDR_W-1:0]  PC_if,
    output logic [ADDR_W-1:0]  PC_id,
    output logic [INSTR_W-1:0] Instr_id,
    output logic               Valid_id,
    output logic               fetch_busy
);

    import pipeline_pkg::*;

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W-1:0]  drain_addr_reg, drain_addr_next;
    logic [INSTR_W-1:0] buf_reg, buf_next;

    logic               deliver;
    logic [ADDR_W-1:0]  target_raw, target, pc_plus4;
    logic               id_load, id_bubble;
    logic [INSTR_W-1:0] id_instr;

    // A redirect only happens under flush, so Branch itself carries no
    // information beyond selecting BranchAddr when Jump is low.
    logic unused_inputs;
    assign unused_inputs = ^{Branch, JumpAddr[1:0], BranchAddr[1:0]};

    assign deliver    = PCWrite & IFIDWrite & ~flush;
    assign target_raw = Jump ? JumpAddr : BranchAddr;
    assign target     = {target_raw[ADDR_W-1:2], 2'b00};
    assign pc_plus4   = pc_reg + ADDR_W'(4);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        buf_next        = buf_reg;
        id_load         = 1'b0;
        id_bubble       = 1'b0;
        id_instr        = imem_rdata;

        if (flush) begin
            id_bubble = 1'b1;
            pc_next   = target;
            case (state_reg)
                ST_FETCH: begin
                    // Unanswered request must be drained on its old address.
                    if (!imem_ack) begin
                        state_next      = ST_DRAIN;
                        drain_addr_next = pc_reg;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) state_next = ST_FETCH;
                end
                default: state_next = ST_FETCH;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (deliver) begin
                            id_load = 1'b1;
                            pc_next = pc_plus4;
                        end else begin
                            buf_next   = imem_rdata;
                            state_next = ST_HOLD;
                        end
                    end else if (IFIDWrite) begin
                        id_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (deliver) begin
                        id_load    = 1'b1;
                        id_instr   = buf_reg;
                        pc_next    = pc_plus4;
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    if (imem_ack) state_next = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= RESET_PC;
            buf_reg        <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            buf_reg        <= buf_next;
        end
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (id_load),
        .bubble     (id_bubble),
        .load_pc    (pc_plus4),
        .load_instr (id_instr),
        .pc_id      (PC_id),
        .instr_id   (Instr_id),
        .valid_id   (Valid_id)
    );

    assign imem_req   = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign imem_addr  = (state_reg == ST_DRAIN) ? drain_addr_reg : pc_reg;
    assign fetch_busy = imem_req & ~imem_ack;
    assign PC_if      = pc_reg;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Randomised bench for if_stage_ctrl against a transaction-level fetch model,
// with directed scenarios pinned by literal expectations.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b0, IFIDWrite = 1'b0, flush = 1'b0;
    logic        Jump = 1'b0, Branch = 1'b0;
    logic [31:0] JumpAddr = '0, BranchAddr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] PC_if, PC_id, Instr_id;
    logic        Valid_id, fetch_busy;

    int checks = 0;
    int errors = 0;

    // Model: what the fetch stage has in flight, what IF/ID must hold.
    logic [31:0] m_pc, m_id_pc, m_id_instr, m_buf, m_stale_addr;
    logic        m_id_valid, m_pending, m_stale, m_buf_ok, m_started;

    if_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .flush      (flush),
        .Jump       (Jump),
        .Branch     (Branch),
        .JumpAddr   (JumpAddr),
        .BranchAddr (BranchAddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .PC_if      (PC_if),
        .PC_id      (PC_id),
        .Instr_id   (Instr_id),
        .Valid_id   (Valid_id),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
        m_buf = 32'h0; m_stale_addr = 32'h0;
        m_pending = 1'b0; m_stale = 1'b0; m_buf_ok = 1'b0; m_started = 1'b0;
    endtask

    task automatic check_outputs();
        chk("pc_if", PC_if, m_pc);
        chk("instr_id", Instr_id, m_id_instr);
        chk1("valid_id", Valid_id, m_id_valid);
        if (m_id_valid) chk("pc_id", PC_id, m_id_pc);
        chk1("imem_req", imem_req, m_pending | m_stale);
        if (m_pending | m_stale)
            chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    endtask

    task automatic id_load(input logic [31:0] instr, input logic [31:0] pc4);
        m_id_instr = instr; m_id_pc = pc4; m_id_valid = 1'b1;
        $display("deliver pc_id=%h instr=%h t=%0t", pc4, instr, $time);
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic step(input logic pcw, input logic ifw, input logic fl,
                        input logic jmp, input logic br,
                        input logic [31:0] ja, input logic [31:0] ba,
                        input logic ackp, input logic force_ack);
        logic [31:0] tgt, rdat, old_pc;
        logic        a;
        check_outputs();
        PCWrite = pcw; IFIDWrite = ifw; flush = fl; Jump = jmp; Branch = br;
        JumpAddr = ja; BranchAddr = ba;
        imem_ack   = ackp & (imem_req | force_ack);
        imem_rdata = mem(imem_addr);
        #1;
        chk1("fetch_busy", fetch_busy, (m_pending | m_stale) & ~imem_ack);
        a    = imem_ack;
        rdat = mem(m_stale ? m_stale_addr : m_pc);
        tgt  = (jmp ? ja : ba) & 32'hFFFF_FFFC;
        if (fl) begin
            m_id_instr = 32'h0; m_id_valid = 1'b0;
            old_pc = m_pc; m_pc = tgt; m_buf_ok = 1'b0;
            if (m_stale) begin
                m_stale = ~a; m_pending = a;
            end else if (m_pending && !a) begin
                m_stale = 1'b1; m_stale_addr = old_pc; m_pending = 1'b0;
            end else begin
                m_pending = 1'b1;
            end
        end else if (m_stale) begin
            if (a) begin m_stale = 1'b0; m_pending = 1'b1; end
        end else if (!m_started) begin
            m_pending = 1'b1;
        end else if (m_buf_ok) begin
            if (pcw && ifw) begin
                id_load(m_buf, m_pc + 32'd4);
                m_pc = m_pc + 32'd4; m_buf_ok = 1'b0; m_pending = 1'b1;
            end
        end else if (m_pending) begin
            if (a) begin
                if (pcw && ifw) begin
                    id_load(rdat, m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_buf = rdat; m_buf_ok = 1'b1; m_pending = 1'b0;
                end
            end else if (ifw) begin
                m_id_instr = 32'h0; m_id_valid = 1'b0;
            end
        end
        m_started = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic ackp, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, ackp, 1'b0);
    endtask

    // Entered at a falling edge; asserts reset mid-cycle, optionally raises a late ack.
    task automatic do_reset(input logic late_ack);
        #2 rst = 1'b1;
        #1;
        chk1("rst_req_async", imem_req, 1'b0);
        chk("rst_pc_if", PC_if, 32'h0);
        chk("rst_pc_id", PC_id, 32'h0);
        chk("rst_instr_id", Instr_id, 32'h0);
        chk1("rst_valid_id", Valid_id, 1'b0);
        imem_ack = late_ack; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        // Zero-wait stream from reset.
        run(1'b1, 6);
        chk("t1_instr", Instr_id, mem(32'h10));
        chk("t1_pc_id", PC_id, 32'h14);
        chk("t1_pc_if", PC_if, 32'h14);

        // Slow fetch: bubbles, stable address, then one advance.
        run(1'b0, 3);
        chk1("t2_valid", Valid_id, 1'b0);
        chk("t2_instr", Instr_id, 32'h0);
        chk("t2_addr", imem_addr, 32'h14);
        run(1'b1, 1);
        chk("t2_instr_after", Instr_id, mem(32'h14));
        chk("t2_pc_if", PC_if, 32'h18);

        // Ack during stall is buffered, no request while held.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk1("t3_req_hold", imem_req, 1'b0);
        chk("t3_instr_hold", Instr_id, mem(32'h14));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t3_instr_buf", Instr_id, mem(32'h18));
        chk("t3_pc_id", PC_id, 32'h1C);
        chk("t3_next_addr", imem_addr, 32'h1C);

        // Redirect to 0x10, then flush+Jump 0x40 while 0x10 is outstanding.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, 32'h10, 1'b1, 1'b0);
        chk("t4_addr_10", imem_addr, 32'h10);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, '0, 1'b0, 1'b0);
        chk("t4_drain_addr", imem_addr, 32'h10);
        chk("t4_pc_if", PC_if, 32'h40);
        chk("t4_instr_nop", Instr_id, 32'h0);
        run(1'b0, 1);
        run(1'b1, 1);
        chk("t4_new_addr", imem_addr, 32'h40);
        chk1("t4_valid", Valid_id, 1'b0);
        run(1'b1, 1);
        chk("t4_instr_40", Instr_id, mem(32'h40));

        // Wrap at the top of the address space; misaligned branch target.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, '0, 1'b1, 1'b0);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        run(1'b1, 1);
        chk("t5_addr_wrap", imem_addr, 32'h0);
        chk("t5_pc_id_wrap", PC_id, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, 32'h23, 1'b1, 1'b0);
        chk("t5_addr_20", imem_addr, 32'h20);

        // Reset mid-fetch with a late ack that must be ignored.
        imem_ack = 1'b0;
        do_reset(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("t6_addr", imem_addr, 32'h0);
        chk1("t6_req", imem_req, 1'b1);
        chk1("t6_valid", Valid_id, 1'b0);
        run(1'b1, 1);
        chk("t6_instr", Instr_id, mem(32'h0));
        chk("t6_pc_id", PC_id, 32'h4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ja, ba;
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                ja = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
                ba = $urandom;
                step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 80,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, ja, ba,
                     $urandom_range(0, 99) < 55, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
